// File: rtl/apb_spi_slave_pkg.sv
// -----------------------------------------------------------------------------
// apb_spi_slave_pkg
// Shared definitions for the APB-controlled SPI target:
//   - register offsets (PADDR[4:2])
//   - shift FSM state encoding
//   - bit positions inside STATUS, CTRL and IRQ_EN
// -----------------------------------------------------------------------------
package apb_spi_slave_pkg;

    // Register offsets, decoded from PADDR[4:2]
    localparam logic [2:0] REG_STATUS = 3'd0;
    localparam logic [2:0] REG_CTRL   = 3'd1;
    localparam logic [2:0] REG_TXDATA = 3'd2;
    localparam logic [2:0] REG_RXDATA = 3'd3;
    localparam logic [2:0] REG_IRQ_EN = 3'd4;

    // Shift FSM states
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_e;

    // STATUS bit/field positions
    localparam int STATUS_BUSY   = 0;
    localparam int STATUS_RX_OVF = 1;
    localparam int STATUS_TX_UDR = 2;
    localparam int STATUS_TX_LSB = 8;
    localparam int STATUS_RX_LSB = 16;

    // CTRL bit positions
    localparam int CTRL_EN  = 0;
    localparam int CTRL_CLR = 1;

    // IRQ_EN bit positions
    localparam int IRQ_RX_NOT_EMPTY = 0;
    localparam int IRQ_TX_EMPTY     = 1;
    localparam int IRQ_ERR          = 2;

endpackage

// File: rtl/apb_spi_slave_if.sv
// -----------------------------------------------------------------------------
// apb_spi_slave_if
// APB3 bus bundle between a bus master and the SPI target register block.
//   PADDR/PWDATA/PWRITE/PSEL/PENABLE : master -> slave
//   PRDATA/PREADY/PSLVERR            : slave  -> master
// A transfer completes in the cycle where PSEL & PENABLE & PREADY are all high.
// -----------------------------------------------------------------------------
interface apb_spi_slave_if #(
    parameter int APB_ADDR_WIDTH = 12
) ();

    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [31:0]               PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [31:0]               PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/spi_master_fifo.sv
// -----------------------------------------------------------------------------
// spi_master_fifo
// Synchronous FIFO with valid/ready ports on both sides and a flush input.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clr          : synchronous flush (empties the FIFO, any push that cycle is lost)
//   o_elements     : current fill level
//   i_valid/i_data/o_ready : write side
//   o_valid/o_data/i_ready : read side
// Handshake: a word moves only in a cycle where valid and ready are both high;
// valid never depends on ready, and o_data is stable while o_valid is high
// and i_ready is low. A push and a pop in the same cycle on a non-empty FIFO
// leave the fill level unchanged.
// -----------------------------------------------------------------------------
module spi_master_fifo #(
    parameter int DATA_WIDTH       = 32,
    parameter int BUFFER_DEPTH     = 8,
    parameter int LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_clr,
    output logic [LOG_BUFFER_DEPTH:0] o_elements,
    output logic [DATA_WIDTH-1:0]     o_data,
    output logic                      o_valid,
    input  logic                      i_ready,
    input  logic                      i_valid,
    input  logic [DATA_WIDTH-1:0]     i_data,
    output logic                      o_ready
);

    localparam logic [LOG_BUFFER_DEPTH-1:0] LAST_PTR = LOG_BUFFER_DEPTH'(BUFFER_DEPTH - 1);
    localparam logic [LOG_BUFFER_DEPTH:0]   FULL_CNT = (LOG_BUFFER_DEPTH + 1)'(BUFFER_DEPTH);

    logic [DATA_WIDTH-1:0]       r_mem [BUFFER_DEPTH];
    logic [LOG_BUFFER_DEPTH-1:0] r_wr_ptr;
    logic [LOG_BUFFER_DEPTH-1:0] r_rd_ptr;
    logic [LOG_BUFFER_DEPTH:0]   r_count;
    logic                        w_push;
    logic                        w_pop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [LOG_BUFFER_DEPTH-1:0] next_ptr(input logic [LOG_BUFFER_DEPTH-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    assign o_valid    = (r_count != '0);
    assign o_ready    = (r_count != FULL_CNT);
    assign o_data     = r_mem[r_rd_ptr];
    assign o_elements = r_count;

    assign w_push = i_valid & o_ready;
    assign w_pop  = i_ready & o_valid;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/spi_slave_sync.sv
// -----------------------------------------------------------------------------
// spi_slave_sync
// Brings the asynchronous SPI host pins into the HCLK domain.
//   i_clk, i_rst_n         : clock, asynchronous active-low reset
//   i_sclk, i_csn, i_sdi   : raw host pins
//   o_sclk_rise/o_sclk_fall: one-cycle edge strobes of sclk
//   o_csn_rise/o_csn_fall  : one-cycle edge strobes of csn
//   o_csn                  : synchronized csn level (flop 3)
//   o_sdi                  : synchronized sdi (flop 2, same depth as the
//                            sclk sample used for edge detection)
// sclk/csn run through three flops: flops 1-2 synchronize, flops 2/3 give
// the edge. An action taken on a strobe lands 3 HCLK after the pin edge.
// -----------------------------------------------------------------------------
module spi_slave_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sclk,
    input  logic i_csn,
    input  logic i_sdi,
    output logic o_sclk_rise,
    output logic o_sclk_fall,
    output logic o_csn_rise,
    output logic o_csn_fall,
    output logic o_csn,
    output logic o_sdi
);

    logic [2:0] r_sclk;
    logic [2:0] r_csn;
    logic [1:0] r_sdi;

    // Reset to the idle bus: sclk low, csn high, so no edge is seen at reset exit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sclk <= 3'b000;
            r_csn  <= 3'b111;
            r_sdi  <= 2'b00;
        end else begin
            r_sclk <= {r_sclk[1:0], i_sclk};
            r_csn  <= {r_csn[1:0], i_csn};
            r_sdi  <= {r_sdi[0], i_sdi};
        end
    end

    assign o_sclk_rise =  r_sclk[1] & ~r_sclk[2];
    assign o_sclk_fall = ~r_sclk[1] &  r_sclk[2];
    assign o_csn_rise  =  r_csn[1]  & ~r_csn[2];
    assign o_csn_fall  = ~r_csn[1]  &  r_csn[2];
    assign o_csn       =  r_csn[2];
    assign o_sdi       =  r_sdi[1];

endmodule

// File: rtl/apb_spi_slave.sv
// -----------------------------------------------------------------------------
// apb_spi_slave
// SPI target (mode 0, 32-bit words, MSB first) with an APB register front end.
// Received words go to an RX FIFO; words from a TX FIFO are shifted out on
// the same frames. All SPI pins are oversampled in the HCLK domain.
//   HCLK, HRESETn : system clock, asynchronous active-low reset
//   apb           : APB slave port (PADDR[4:2] selects the register)
//   events_o      : [0] level interrupt, [1] one-cycle end-of-transfer pulse
//   spi_sclk, spi_csn, spi_sdi : host-driven pins (asynchronous)
//   spi_sdo, spi_sdo_oe        : MISO and its output enable
// Registers: 0 STATUS (RO), 1 CTRL (RW), 2 TXDATA (WO, push),
//            3 RXDATA (RO, pop), 4 IRQ_EN (RW); other offsets read 0.
// -----------------------------------------------------------------------------
module apb_spi_slave
    import apb_spi_slave_pkg::*;
#(
    parameter int BUFFER_DEPTH   = 8,
    parameter int APB_ADDR_WIDTH = 12
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    apb_spi_slave_if.slave      apb,
    output logic [1:0]          events_o,
    input  logic                spi_sclk,
    input  logic                spi_csn,
    input  logic                spi_sdi,
    output logic                spi_sdo,
    output logic                spi_sdo_oe
);

    localparam int CNT_W = $clog2(BUFFER_DEPTH) + 1;

    // Synchronized pin view
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_csn_rise;
    logic w_csn_fall;
    logic w_csn_sync;
    logic w_sdi;

    // APB decode
    logic [APB_ADDR_WIDTH-1:0] w_paddr;
    logic [2:0]                w_reg;
    logic                      w_access;
    logic                      w_wr;
    logic                      w_rd;
    logic                      w_tx_apb_push;
    logic                      w_rx_apb_pop;
    logic [31:0]               w_status;

    // Control/status registers
    logic       r_en;
    logic       r_clr;
    logic [2:0] r_irq_en;
    logic       r_rx_ovf;
    logic       r_tx_udr;
    logic       r_eot;

    // FIFO ports
    logic [CNT_W-1:0] w_tx_elems;
    logic [CNT_W-1:0] w_rx_elems;
    logic [31:0]      w_tx_data;
    logic             w_tx_valid;
    logic             w_tx_ready;
    logic [31:0]      w_rx_data;
    logic             w_rx_valid;
    logic             w_rx_ready;
    logic [31:0]      w_rx_word;

    // Shift engine
    spi_state_e r_state;
    spi_state_e w_next_state;
    logic       w_frame_start;
    logic       w_tx_pop;
    logic       w_tx_shift;
    logic       w_rx_sample;
    logic       w_rx_push;
    logic [31:0] r_tx_sh;
    logic [31:0] r_rx_sh;
    logic [4:0]  r_bit_cnt;
    logic        r_word_done;

    logic w_unused;

    // ------------------------------------------------------------------
    // Pin synchronizers
    // ------------------------------------------------------------------
    spi_slave_sync u_sync (
        .i_clk       (HCLK),
        .i_rst_n     (HRESETn),
        .i_sclk      (spi_sclk),
        .i_csn       (spi_csn),
        .i_sdi       (spi_sdi),
        .o_sclk_rise (w_sclk_rise),
        .o_sclk_fall (w_sclk_fall),
        .o_csn_rise  (w_csn_rise),
        .o_csn_fall  (w_csn_fall),
        .o_csn       (w_csn_sync),
        .o_sdi       (w_sdi)
    );

    // ------------------------------------------------------------------
    // FIFOs: TX is filled by APB and drained by the shifter; RX the reverse.
    // ------------------------------------------------------------------
    spi_master_fifo #(
        .DATA_WIDTH   (32),
        .BUFFER_DEPTH (BUFFER_DEPTH)
    ) u_tx_fifo (
        .i_clk      (HCLK),
        .i_rst_n    (HRESETn),
        .i_clr      (r_clr),
        .o_elements (w_tx_elems),
        .o_data     (w_tx_data),
        .o_valid    (w_tx_valid),
        .i_ready    (w_tx_pop),
        .i_valid    (w_tx_apb_push),
        .i_data     (apb.PWDATA),
        .o_ready    (w_tx_ready)
    );

    spi_master_fifo #(
        .DATA_WIDTH   (32),
        .BUFFER_DEPTH (BUFFER_DEPTH)
    ) u_rx_fifo (
        .i_clk      (HCLK),
        .i_rst_n    (HRESETn),
        .i_clr      (r_clr),
        .o_elements (w_rx_elems),
        .o_data     (w_rx_data),
        .o_valid    (w_rx_valid),
        .i_ready    (w_rx_apb_pop),
        .i_valid    (w_rx_push),
        .i_data     (w_rx_word),
        .o_ready    (w_rx_ready)
    );

    // ------------------------------------------------------------------
    // APB decode and read mux. The bus never waits, so read data and the
    // error flag are combinational in the access cycle and zero otherwise.
    // ------------------------------------------------------------------
    assign w_paddr       = apb.PADDR;
    assign w_reg         = w_paddr[4:2];
    assign w_access      = apb.PSEL & apb.PENABLE;
    assign w_wr          = w_access &  apb.PWRITE;
    assign w_rd          = w_access & ~apb.PWRITE;
    assign w_tx_apb_push = w_wr & (w_reg == REG_TXDATA);
    assign w_rx_apb_pop  = w_rd & (w_reg == REG_RXDATA);

    always_comb begin
        w_status                              = '0;
        w_status[STATUS_BUSY]                 = (r_state == SHIFT);
        w_status[STATUS_RX_OVF]               = r_rx_ovf;
        w_status[STATUS_TX_UDR]               = r_tx_udr;
        w_status[STATUS_TX_LSB +: 8]          = 8'(w_tx_elems);
        w_status[STATUS_RX_LSB +: 8]          = 8'(w_rx_elems);
    end

    assign apb.PREADY = 1'b1;

    always_comb begin
        apb.PRDATA  = '0;
        apb.PSLVERR = 1'b0;
        if (w_access) begin
            case (w_reg)
                REG_STATUS: begin
                    if (w_rd) apb.PRDATA = w_status;
                end
                REG_CTRL: begin
                    if (w_rd) apb.PRDATA = {30'd0, r_clr, r_en};
                end
                REG_TXDATA: begin
                    if (w_wr && !w_tx_ready) apb.PSLVERR = 1'b1;
                end
                REG_RXDATA: begin
                    if (w_rd) begin
                        if (w_rx_valid) apb.PRDATA  = w_rx_data;
                        else            apb.PSLVERR = 1'b1;
                    end
                end
                REG_IRQ_EN: begin
                    if (w_rd) apb.PRDATA = {29'd0, r_irq_en};
                end
                default: begin
                    apb.PRDATA  = '0;
                    apb.PSLVERR = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control, sticky flags and event pulse
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_en     <= 1'b0;
            r_clr    <= 1'b0;
            r_irq_en <= '0;
            r_rx_ovf <= 1'b0;
            r_tx_udr <= 1'b0;
            r_eot    <= 1'b0;
        end else begin
            r_clr <= 1'b0;
            if (w_wr && (w_reg == REG_CTRL)) begin
                r_en  <= apb.PWDATA[CTRL_EN];
                r_clr <= apb.PWDATA[CTRL_CLR];
            end
            if (w_wr && (w_reg == REG_IRQ_EN)) begin
                r_irq_en <= apb.PWDATA[2:0];
            end
            // clr takes the FIFOs and the stickies back to a clean state together
            if (r_clr) begin
                r_rx_ovf <= 1'b0;
                r_tx_udr <= 1'b0;
            end else begin
                if (w_rx_push && !w_rx_ready) r_rx_ovf <= 1'b1;
                if (w_tx_pop  && !w_tx_valid) r_tx_udr <= 1'b1;
            end
            r_eot <= r_en & w_csn_rise;
        end
    end

    assign events_o[0] = (r_irq_en[IRQ_RX_NOT_EMPTY] & w_rx_valid)
                       | (r_irq_en[IRQ_TX_EMPTY]     & ~w_tx_valid)
                       | (r_irq_en[IRQ_ERR]          & (r_rx_ovf | r_tx_udr));
    assign events_o[1] = r_eot;

    // ------------------------------------------------------------------
    // Shift FSM
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_frame_start = 1'b0;
        w_tx_pop      = 1'b0;
        w_tx_shift    = 1'b0;
        w_rx_sample   = 1'b0;
        w_rx_push     = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_en && w_csn_fall) begin
                    w_next_state  = SHIFT;
                    w_frame_start = 1'b1;
                    w_tx_pop      = 1'b1;
                end
            end
            SHIFT: begin
                // Disable or frame end abandons any partial word silently.
                if (!r_en || w_csn_rise) begin
                    w_next_state = IDLE;
                end else begin
                    if (w_sclk_rise) begin
                        w_rx_sample = 1'b1;
                        w_rx_push   = (r_bit_cnt == 5'd31);
                    end
                    if (w_sclk_fall) begin
                        w_tx_pop   =  r_word_done;
                        w_tx_shift = ~r_word_done;
                    end
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // The 32nd bit is taken straight from the pin sample, not from r_rx_sh.
    assign w_rx_word = {r_rx_sh[30:0], w_sdi};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_tx_sh     <= '0;
            r_rx_sh     <= '0;
            r_bit_cnt   <= '0;
            r_word_done <= 1'b0;
        end else begin
            if (w_tx_pop) begin
                // An empty TX FIFO sends zeros for the whole word.
                r_tx_sh <= w_tx_valid ? w_tx_data : '0;
            end else if (w_tx_shift) begin
                r_tx_sh <= {r_tx_sh[30:0], 1'b0};
            end

            if (w_frame_start) begin
                r_bit_cnt <= '0;
            end else if (w_rx_sample) begin
                r_rx_sh   <= w_rx_word;
                r_bit_cnt <= r_bit_cnt + 5'd1;
            end

            if (w_frame_start || w_tx_pop) begin
                r_word_done <= 1'b0;
            end else if (w_rx_push) begin
                r_word_done <= 1'b1;
            end
        end
    end

    assign spi_sdo    = r_tx_sh[31];
    assign spi_sdo_oe = r_en & ~w_csn_sync;

    assign w_unused = ^{w_paddr[APB_ADDR_WIDTH-1:5], w_paddr[1:0], r_rx_sh[31]};

endmodule

// File: tb/tb_apb_spi_slave.sv
module tb_apb_spi_slave;
    import apb_spi_slave_pkg::*;

    localparam int DEPTH = 8;

    logic       HCLK;
    logic       HRESETn;
    logic [1:0] events_o;
    logic       spi_sclk;
    logic       spi_csn;
    logic       spi_sdi;
    logic       spi_sdo;
    logic       spi_sdo_oe;

    apb_spi_slave_if #(.APB_ADDR_WIDTH(12)) apb_if ();

    apb_spi_slave #(
        .BUFFER_DEPTH   (DEPTH),
        .APB_ADDR_WIDTH (12)
    ) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .apb        (apb_if),
        .events_o   (events_o),
        .spi_sclk   (spi_sclk),
        .spi_csn    (spi_csn),
        .spi_sdi    (spi_sdi),
        .spi_sdo    (spi_sdo),
        .spi_sdo_oe (spi_sdo_oe)
    );

    // clock / reset
    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int n_cmp = 0;
    int n_err = 0;
    int eot_cnt = 0;

    logic [31:0] host_tx [0:9];
    logic [31:0] host_rx [0:9];

    always @(negedge HCLK) begin
        if (events_o[1] === 1'b1) eot_cnt++;
    end

    // Run-time guard: no test should come anywhere near this.
    initial begin
        #500000;
        $display("FAIL timeout: observed no completion expected completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // APB driver tasks: setup at negedge, access phase next negedge,
    // sample completion #1 after, release after the completing posedge.
    task automatic apb_write(input logic [2:0] r, input logic [31:0] d, output logic e);
        @(negedge HCLK);
        apb_if.PADDR   = {7'd0, r, 2'b00};
        apb_if.PWDATA  = d;
        apb_if.PWRITE  = 1'b1;
        apb_if.PSEL    = 1'b1;
        apb_if.PENABLE = 1'b0;
        @(negedge HCLK);
        apb_if.PENABLE = 1'b1;
        #1;
        e = apb_if.PSLVERR;
        @(posedge HCLK);
        #1;
        apb_if.PSEL    = 1'b0;
        apb_if.PENABLE = 1'b0;
        apb_if.PWRITE  = 1'b0;
    endtask

    task automatic apb_read(input logic [2:0] r, output logic [31:0] d, output logic e);
        @(negedge HCLK);
        apb_if.PADDR   = {7'd0, r, 2'b00};
        apb_if.PWRITE  = 1'b0;
        apb_if.PSEL    = 1'b1;
        apb_if.PENABLE = 1'b0;
        @(negedge HCLK);
        apb_if.PENABLE = 1'b1;
        #1;
        d = apb_if.PRDATA;
        e = apb_if.PSLVERR;
        @(posedge HCLK);
        #1;
        apb_if.PSEL    = 1'b0;
        apb_if.PENABLE = 1'b0;
    endtask

    // SPI host, mode 0, sclk = HCLK/8. sdi changes in the low phase; sdo is
    // captured just before each rising sclk, like a real host would.
    task automatic spi_frame(input int nbits);
        int w;
        int b;
        @(negedge HCLK);
        spi_csn = 1'b0;
        repeat (8) @(negedge HCLK);
        for (int i = 0; i < nbits; i++) begin
            w = i / 32;
            b = 31 - (i % 32);
            spi_sdi = host_tx[w][b];
            repeat (4) @(negedge HCLK);
            host_rx[w][b] = spi_sdo;
            spi_sclk = 1'b1;
            repeat (4) @(negedge HCLK);
            spi_sclk = 1'b0;
        end
        repeat (4) @(negedge HCLK);
        spi_csn = 1'b1;
        repeat (8) @(negedge HCLK);
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        int          eot_prev;

        HRESETn        = 1'b0;
        spi_sclk       = 1'b0;
        spi_csn        = 1'b1;
        spi_sdi        = 1'b0;
        apb_if.PADDR   = '0;
        apb_if.PWDATA  = '0;
        apb_if.PWRITE  = 1'b0;
        apb_if.PSEL    = 1'b0;
        apb_if.PENABLE = 1'b0;
        for (int i = 0; i < 10; i++) begin
            host_tx[i] = '0;
            host_rx[i] = '0;
        end
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);

        // ---- reset state
        check("rst_sdo_oe", {31'd0, spi_sdo_oe}, 32'd0);
        check("rst_sdo", {31'd0, spi_sdo}, 32'd0);
        check("rst_events", {30'd0, events_o}, 32'd0);
        check("rst_pready", {31'd0, apb_if.PREADY}, 32'd1);
        check("rst_prdata", apb_if.PRDATA, 32'd0);
        apb_read(REG_STATUS, rd, err);
        check("rst_status", rd, 32'd0);
        apb_read(REG_CTRL, rd, err);
        check("rst_ctrl", rd, 32'd0);
        apb_read(3'd5, rd, err);
        check("unmapped_rd", rd, 32'd0);
        check("unmapped_err", {31'd0, err}, 32'd0);

        // ---- single word exchange
        apb_write(REG_CTRL, 32'h1, err);
        apb_write(REG_TXDATA, 32'hA5A5_0F0F, err);
        check("tx_push_err", {31'd0, err}, 32'd0);
        host_tx[0] = 32'h1234_5678;
        eot_prev = eot_cnt;
        spi_frame(32);
        check("t1_sdo_word", host_rx[0], 32'hA5A5_0F0F);
        check("t1_eot_pulses", eot_cnt - eot_prev, 32'd1);
        // the closing sclk fall tries to reload from the now-empty TX FIFO
        apb_read(REG_STATUS, rd, err);
        check("t1_status", rd, 32'h0001_0004);
        apb_read(REG_RXDATA, rd, err);
        check("t1_rxdata", rd, 32'h1234_5678);
        check("t1_rx_err", {31'd0, err}, 32'd0);
        apb_read(REG_RXDATA, rd, err);
        check("rx_empty_data", rd, 32'd0);
        check("rx_empty_err", {31'd0, err}, 32'd1);

        // ---- two-word frame, one TX word -> underrun
        apb_write(REG_CTRL, 32'h3, err);
        apb_read(REG_STATUS, rd, err);
        check("t2_status_clr", rd, 32'd0);
        apb_read(REG_CTRL, rd, err);
        check("t2_ctrl_selfclr", rd, 32'h1);
        apb_write(REG_TXDATA, 32'hDEAD_BEEF, err);
        host_tx[0] = 32'hCAFE_F00D;
        host_tx[1] = 32'h0BAD_C0DE;
        spi_frame(64);
        check("t2_sdo_w0", host_rx[0], 32'hDEAD_BEEF);
        check("t2_sdo_w1", host_rx[1], 32'h0000_0000);
        apb_read(REG_STATUS, rd, err);
        check("t2_status", rd, 32'h0002_0004);
        check("t2_irq_off", {31'd0, events_o[0]}, 32'd0);
        apb_write(REG_IRQ_EN, 32'h4, err);
        check("t2_irq_err", {31'd0, events_o[0]}, 32'd1);
        apb_write(REG_IRQ_EN, 32'h1, err);
        check("t2_irq_rxne", {31'd0, events_o[0]}, 32'd1);
        apb_read(REG_RXDATA, rd, err);
        check("t2_rx0", rd, 32'hCAFE_F00D);
        apb_read(REG_RXDATA, rd, err);
        check("t2_rx1", rd, 32'h0BAD_C0DE);
        check("t2_irq_rx_drained", {31'd0, events_o[0]}, 32'd0);
        apb_write(REG_IRQ_EN, 32'h0, err);

        // ---- RX overflow
        apb_write(REG_CTRL, 32'h3, err);
        for (int i = 0; i < DEPTH; i++) host_tx[i] = 32'h1000_0000 + i;
        spi_frame(32 * DEPTH);
        apb_read(REG_STATUS, rd, err);
        check("t3_status_full", rd, 32'h0008_0004);
        host_tx[0] = 32'hFFFF_0000;
        spi_frame(32);
        apb_read(REG_STATUS, rd, err);
        check("t3_status_ovf", rd, 32'h0008_0006);
        apb_read(REG_RXDATA, rd, err);
        check("t3_rx_first", rd, 32'h1000_0000);

        // ---- partial frame then full frame
        apb_write(REG_CTRL, 32'h3, err);
        host_tx[0] = 32'h55AA_55AA;
        eot_prev = eot_cnt;
        spi_frame(20);
        check("t4_eot_partial", eot_cnt - eot_prev, 32'd1);
        apb_read(REG_STATUS, rd, err);
        check("t4_status_partial", rd, 32'h0000_0004);
        host_tx[0] = 32'h9ABC_DEF0;
        spi_frame(32);
        apb_read(REG_RXDATA, rd, err);
        check("t4_rx_after_partial", rd, 32'h9ABC_DEF0);

        // ---- TX full and clr
        for (int i = 0; i < DEPTH; i++) apb_write(REG_TXDATA, 32'h7000_0000 + i, err);
        check("t5_last_push_err", {31'd0, err}, 32'd0);
        apb_write(REG_TXDATA, 32'hBAD0_BAD0, err);
        check("t5_full_push_err", {31'd0, err}, 32'd1);
        apb_read(REG_STATUS, rd, err);
        check("t5_status_full", rd, 32'h0000_0804);
        apb_write(REG_CTRL, 32'h3, err);
        apb_read(REG_STATUS, rd, err);
        check("t5_status_clr", rd, 32'd0);

        // ---- disable mid-frame
        host_tx[0] = 32'hFEDC_BA98;
        eot_prev = eot_cnt;
        fork
            spi_frame(32);
            begin
                repeat (90) @(negedge HCLK);
                check("t6_sdo_oe_on", {31'd0, spi_sdo_oe}, 32'd1);
                apb_read(REG_STATUS, rd, err);
                check("t6_busy_mid", {31'd0, rd[STATUS_BUSY]}, 32'd1);
                apb_write(REG_CTRL, 32'h0, err);
                check("t6_sdo_oe_off", {31'd0, spi_sdo_oe}, 32'd0);
                apb_read(REG_STATUS, rd, err);
                check("t6_busy_off", {31'd0, rd[STATUS_BUSY]}, 32'd0);
            end
        join
        check("t6_eot_none", eot_cnt - eot_prev, 32'd0);
        check("t6_events", {30'd0, events_o}, 32'd0);
        apb_read(REG_STATUS, rd, err);
        check("t6_rx_elems", {24'd0, rd[23:16]}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
